// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with fixed read latency.
// Ports: clk, reset (async, active-low); req/we/addr/be/wdata per requester
// (packed, requester i in slice i); gnt/rvalid one-hot; rdata shared;
// *_RAM drive the RAM. Define ARB_ROUND_ROBIN_EN for round-robin priority,
// otherwise requester 0 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W/8-1:0] be,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     address_RAM,
  output logic [DATA_W/8-1:0]   byteena_RAM,
  output logic [DATA_W-1:0]     writeData_RAM,
  input  logic [DATA_W-1:0]     readData_RAM,
  output logic                  rden_RAM,
  output logic                  wren_RAM
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic       owner_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic       ptr_q;
`endif

  logic any;
  logic win;
  logic rv_hit;

  // Outputs are gated by reset so everything reads 0 while it is low.
  always_comb begin
    any = reset && (state_q == IDLE) && (req != 2'b00);
`ifdef ARB_ROUND_ROBIN_EN
    win = (req == 2'b11) ? ptr_q : req[1];
`else
    win = ~req[0];
`endif
    rv_hit = reset && (state_q == RD_WAIT) && (cnt_q == 3'd0);
  end

  always_comb begin
    gnt           = 2'b00;
    address_RAM   = '0;
    byteena_RAM   = '0;
    writeData_RAM = '0;
    wren_RAM      = 1'b0;
    rden_RAM      = 1'b0;
    if (any) begin
      gnt           = win ? 2'b10 : 2'b01;
      address_RAM   = win ? addr[2*ADDR_W-1:ADDR_W]
                          : addr[ADDR_W-1:0];
      byteena_RAM   = win ? be[2*BE_W-1:BE_W]
                          : be[BE_W-1:0];
      writeData_RAM = win ? wdata[2*DATA_W-1:DATA_W]
                          : wdata[DATA_W-1:0];
      wren_RAM      = we[win];
      rden_RAM      = ~we[win];
    end
  end

  assign rvalid = {rv_hit & owner_q, rv_hit & ~owner_q};
  assign rdata  = reset ? readData_RAM : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q <= ~win;
`endif
            if (!we[win]) begin
              state_q <= RD_WAIT;
              cnt_q   <= 3'(RD_LAT - 1);
              owner_q <= win;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 3'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized + directed bench for ram_port_arbiter against a
// cycle-count reference model of the arbitration rules.
module tb_ram_port_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 256;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*BW-1:0] be = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, writeData_RAM;
  logic [DW-1:0]   readData_RAM = '0;
  logic [AW-1:0]   address_RAM;
  logic [BW-1:0]   byteena_RAM;
  logic            rden_RAM, wren_RAM;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr(addr), .be(be), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .address_RAM(address_RAM), .byteena_RAM(byteena_RAM),
    .writeData_RAM(writeData_RAM), .readData_RAM(readData_RAM),
    .rden_RAM(rden_RAM), .wren_RAM(wren_RAM)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: cycle index, earliest free cycle, pending read.
  int cyc = 0;
  int next_free = 0;
  int rv_cyc = 0;
  bit rv_pend = 1'b0;
  bit rv_own = 1'b0;
  bit prio = 1'b0;

  bit            p_v[2];
  bit            p_we[2];
  logic [AW-1:0] p_a[2];
  logic [BW-1:0] p_be[2];
  logic [DW-1:0] p_d[2];
  logic [1:0]    last_gnt;
  logic [1:0]    last_rv;

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic set_cmd(int i, bit w, logic [AW-1:0] a,
                         logic [BW-1:0] b, logic [DW-1:0] d);
    p_v[i]  = 1'b1;
    p_we[i] = w;
    p_a[i]  = a;
    p_be[i] = b;
    p_d[i]  = d;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      req[i]             = p_v[i];
      we[i]              = p_v[i] ? p_we[i] : 1'($urandom());
      addr[i*AW +: AW]   = p_v[i] ? p_a[i] : AW'($urandom());
      be[i*BW +: BW]     = p_v[i] ? p_be[i] : BW'($urandom());
      wdata[i*DW +: DW]  = p_v[i] ? p_d[i] : rnd_word();
    end
  endtask

  task automatic do_reset(int n);
    #1;
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req          = 2'b11;
      we           = 2'($urandom());
      addr         = 2*AW'($urandom());
      be           = 2*BW'($urandom());
      wdata        = {rnd_word(), rnd_word()};
      readData_RAM = rnd_word();
      #1;
      chk("rst_gnt", gnt, '0);
      chk("rst_rvalid", rvalid, '0);
      chk("rst_rden", rden_RAM, '0);
      chk("rst_wren", wren_RAM, '0);
      chk("rst_addr", address_RAM, '0);
      chk("rst_be", byteena_RAM, '0);
      chk("rst_wdata", writeData_RAM, '0);
      chk("rst_rdata", rdata, '0);
      @(posedge clk);
      cyc++;
    end
    #1;
    reset     = 1'b1;
    next_free = cyc;
    rv_pend   = 1'b0;
    prio      = 1'b0;
    p_v[0]    = 1'b0;
    p_v[1]    = 1'b0;
  endtask

  task automatic step(bit rnd, logic [DW-1:0] ram);
    bit            g_ok;
    bit            w;
    logic [1:0]    eg, erv;
    @(negedge clk);
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin
        if (p_v[i]) begin
          if ($urandom_range(0, 9) == 0) p_v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          set_cmd(i, 1'($urandom()), AW'($urandom()),
                  BW'($urandom()), rnd_word());
        end
      end
    end
    drive();
    readData_RAM = ram;
    #1;
    g_ok = (cyc >= next_free) && (p_v[0] || p_v[1]);
    w    = (p_v[0] && p_v[1]) ? (RR ? prio : 1'b0) : p_v[1];
    eg   = g_ok ? (w ? 2'b10 : 2'b01) : 2'b00;
    erv  = (rv_pend && rv_cyc == cyc) ? (rv_own ? 2'b10 : 2'b01) : 2'b00;
    chk("gnt", gnt, eg);
    chk("wren", wren_RAM, g_ok && p_we[w]);
    chk("rden", rden_RAM, g_ok && !p_we[w]);
    chk("addr", address_RAM, g_ok ? p_a[w] : '0);
    chk("be", byteena_RAM, g_ok ? p_be[w] : '0);
    chk("wdata", writeData_RAM, g_ok ? p_d[w] : '0);
    chk("rvalid", rvalid, erv);
    chk("rdata", rdata, ram);
    last_gnt = gnt;
    last_rv  = rvalid;
    @(posedge clk);
    if (erv != 2'b00) rv_pend = 1'b0;
    if (g_ok) begin
      prio = !w;
      if (p_we[w]) begin
        next_free = cyc + 1;
      end else begin
        next_free = cyc + LAT + 1;
        rv_pend   = 1'b1;
        rv_cyc    = cyc + LAT;
        rv_own    = w;
      end
      p_v[w] = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    logic [DW-1:0] a5;
    a5 = {BW{8'hA5}};
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    do_reset(2);

    // Read from requester 0; requester 1 waits behind it.
    set_cmd(0, 1'b0, 14'h0010, '1, rnd_word());
    step(1'b0, a5);
    chk("r0_read_gnt", last_gnt, 2'b01);
    set_cmd(1, 1'b1, 14'h0123, 32'h1, rnd_word());
    step(1'b0, a5);
    chk("rdwait_gnt", last_gnt, 2'b00);
    step(1'b0, a5);
    chk("r0_rvalid", last_rv, 2'b01);
    step(1'b0, a5);
    chk("next_gnt", last_gnt, 2'b10);

    // Requester 1 write at the top address, low half enabled.
    set_cmd(1, 1'b1, 14'h3FFF, 32'h0000FFFF,
            {{(DW/2){1'b0}}, {(DW/2){1'b1}}});
    step(1'b0, rnd_word());
    chk("r1_write_gnt", last_gnt, 2'b10);
    chk("r1_write_rv", last_rv, 2'b00);

    // Both requesters writing continuously from reset.
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++)
        if (!p_v[i])
          set_cmd(i, 1'b1, AW'($urandom()), BW'($urandom()), rnd_word());
      step(1'b0, rnd_word());
      chk("arb_seq", last_gnt,
          RR ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b01);
    end
    if (!p_v[1])
      set_cmd(1, 1'b1, AW'($urandom()), BW'($urandom()), rnd_word());
    p_v[0] = 1'b0;
    step(1'b0, rnd_word());
    chk("drop_r0_gnt", last_gnt, 2'b10);

    // Reset in the middle of a read aborts it.
    set_cmd(0, 1'b0, AW'($urandom()), BW'($urandom()), rnd_word());
    step(1'b0, rnd_word());
    chk("abort_gnt", last_gnt, 2'b01);
    do_reset(3);
    set_cmd(1, 1'b1, AW'($urandom()), BW'($urandom()), rnd_word());
    step(1'b0, rnd_word());
    chk("post_rst_gnt", last_gnt, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, rnd_word());
      chk("abort_rv", last_rv, 2'b00);
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) step(1'b1, rnd_word());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
